// File: rtl/normal_sched.sv
// -----------------------------------------------------------------------------
// normal_sched
//   Shares one fixed-latency inv_sqrt engine among N_REQ requesters. One
//   request is granted at a time (round-robin), its operands are held on the
//   engine for the full latency, and the captured result is returned with the
//   requester ID over a valid/ready response port. An exact (0,0,0) vector
//   bypasses the engine and is flagged with rsp_zero.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid[N_REQ]      per-requester request
//   req_x/y/z[N_REQ*W]    packed operands, requester i at [i*W +: W]
//   req_ready[N_REQ]      one-hot accept strobe (IDLE only)
//   eng_x/y/z[W]          operands to the engine, held from accept to response
//   eng_out[W]            engine result
//   rsp_valid, rsp_ready  response handshake
//   rsp_data[W]           1/sqrt(x^2+y^2+z^2), 1Q23
//   rsp_id[ID_W]          requester served
//   rsp_zero              input vector was exactly zero
//   busy                  high outside IDLE
// -----------------------------------------------------------------------------
module normal_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int W     = 24,
    parameter int LAT   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_x,
    input  logic [N_REQ*W-1:0]   req_y,
    input  logic [N_REQ*W-1:0]   req_z,
    output logic [N_REQ-1:0]     req_ready,
    output logic [W-1:0]         eng_x,
    output logic [W-1:0]         eng_y,
    output logic [W-1:0]         eng_z,
    input  logic [W-1:0]         eng_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_zero,
    output logic                 busy
);

    localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [ID_W-1:0]        r_last;
    logic signed [W-1:0]    r_op_x;
    logic signed [W-1:0]    r_op_y;
    logic signed [W-1:0]    r_op_z;
    logic [W-1:0]           r_rsp_data;
    logic [ID_W-1:0]        r_rsp_id;
    logic                   r_rsp_zero;

    logic                   w_gnt_vld;
    logic [ID_W-1:0]        w_gnt_idx;
    logic [N_REQ-1:0]       w_gnt_onehot;
    logic [W-1:0]           w_sel_x;
    logic [W-1:0]           w_sel_y;
    logic [W-1:0]           w_sel_z;
    logic                   w_sel_zero;

    // Round-robin pick: first set bit of mask searching upward from last+1,
    // wrapping modulo N_REQ. Returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                              input logic [ID_W-1:0]  last);
        logic              found;
        logic [ID_W-1:0]   sel;
        logic [N_REQ-1:0]  sh;
        int                idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            sh  = mask >> idx;
            if (!found && sh[0]) begin
                found = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        {w_gnt_vld, w_gnt_idx} = rr_pick(req_valid, r_last);
    end

    assign w_gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    assign w_sel_x      = req_x[w_gnt_idx*W +: W];
    assign w_sel_y      = req_y[w_gnt_idx*W +: W];
    assign w_sel_z      = req_z[w_gnt_idx*W +: W];
    assign w_sel_zero   = (w_sel_x == '0) && (w_sel_y == '0) && (w_sel_z == '0);

    // The strobe is combinational so the requester sees it in the cycle the
    // grant is taken; reset masks it even though the FSM is already IDLE.
    assign req_ready = (r_state == S_IDLE && !rst && w_gnt_vld) ? w_gnt_onehot : '0;

    // Engine operands only move at an accept edge, so they are stable for
    // the whole RUN/RESP window.
    assign eng_x     = r_op_x;
    assign eng_y     = r_op_y;
    assign eng_z     = r_op_z;

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_zero  = r_rsp_zero;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= ID_W'(N_REQ - 1);
            r_op_x     <= '0;
            r_op_y     <= '0;
            r_op_z     <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_op_x   <= w_sel_x;
                        r_op_y   <= w_sel_y;
                        r_op_z   <= w_sel_z;
                        r_rsp_id <= w_gnt_idx;
                        r_last   <= w_gnt_idx;
                        if (w_sel_zero) begin
                            // Exact zero has no finite result; skip the engine.
                            r_rsp_data <= '0;
                            r_rsp_zero <= 1'b1;
                            r_state    <= S_RESP;
                        end else begin
                            r_cnt      <= CNT_W'(LAT);
                            r_rsp_zero <= 1'b0;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // LAT+1 cycles in RUN: the engine output has been valid
                    // for one full cycle when it is captured.
                    if (r_cnt == '0) begin
                        r_rsp_data <= eng_out;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normal_sched.sv
module tb_normal_sched;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int W     = 24;
    localparam int LAT   = 11;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*W-1:0]   req_x, req_y, req_z;
    logic [N_REQ-1:0]     req_ready;
    logic [W-1:0]         eng_x, eng_y, eng_z, eng_out;
    logic                 rsp_valid, rsp_ready;
    logic [W-1:0]         rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_zero, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int stab_err = 0;
    int m_last;

    normal_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ready(req_ready),
        .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z), .eng_out(eng_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine stand-in: LAT-deep delay line of eng_x ^ 5A5A5A.
    logic [W-1:0] dl [LAT];
    always @(posedge clk) begin
        dl[0] <= eng_x ^ 24'h5A5A5A;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign eng_out = dl[LAT-1];

    // Operand stability watch: engine inputs must not move while busy.
    logic             mon_pb = 1'b0;
    logic [3*W-1:0]   mon_prev = '0;
    always @(negedge clk) begin
        if (rst) begin
            mon_pb = 1'b0;
        end else begin
            if (mon_pb && busy && {eng_x, eng_y, eng_z} != mon_prev) stab_err++;
            mon_pb   = busy;
            mon_prev = {eng_x, eng_y, eng_z};
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Round-robin rule: first valid requester after the last one served.
    function automatic int next_grant(input logic [N_REQ-1:0] mask, input int last);
        for (int s = 1; s <= N_REQ; s++) begin
            int i;
            i = (last + s) % N_REQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] oh(input int i);
        return N_REQ'(1) << i;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_z[i*W +: W] = z;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_last = N_REQ - 1;
    endtask

    // One transaction: present mask, wait for the grant, follow it to the
    // response, optionally stall the response, then complete the handshake.
    task automatic serve(input logic [N_REQ-1:0] mask, input int stall, input int wd,
                         output logic [N_REQ-1:0] o_rdy, output logic [W-1:0] o_data,
                         output logic o_zero, output logic [ID_W-1:0] o_id, output int o_lat);
        int t, k, g;
        logic [N_REQ-1:0] rest;
        logic bad;
        logic [W-1:0] gx;
        o_rdy = '0; o_data = '0; o_zero = 1'b0; o_id = '0; o_lat = -1;
        rsp_ready = (stall == 0);
        req_valid = mask;
        #1;
        t = 0;
        while (req_ready == '0 && t < 40) begin
            @(posedge clk); #2; t++;
        end
        if (req_ready == '0) begin
            check("grant_seen", 64'(req_ready != '0), 64'(1));
            req_valid = '0;
            return;
        end
        o_rdy = req_ready;
        g = -1;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i] && g < 0) g = i;
        gx   = req_x[g*W +: W];
        rest = mask & ~req_ready;
        @(posedge clk); #1;
        req_valid = rest;
        check("eng_x_latched", 64'(eng_x), 64'(gx));
        k = 0; bad = 1'b0;
        while (!rsp_valid && k < 40) begin
            if (req_ready != '0) bad = 1'b1;
            if (wd >= 0 && k == 2) req_valid[wd] = 1'b1;
            if (wd >= 0 && k == 6) req_valid[wd] = 1'b0;
            @(posedge clk); #1; k++;
        end
        check("no_grant_busy", 64'(bad), 64'(0));
        o_lat = k; o_data = rsp_data; o_zero = rsp_zero; o_id = rsp_id;
        if (!rsp_valid) begin
            req_valid = '0;
            rsp_ready = 1'b1;
            return;
        end
        if (stall > 0) begin
            bad = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                if (!rsp_valid || rsp_data !== o_data || rsp_id !== o_id ||
                    rsp_zero !== o_zero || req_ready != '0) bad = 1'b1;
            end
            check("hold_stable", 64'(bad), 64'(0));
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("resp_done", 64'({rsp_valid, busy}), 64'(0));
        if (rest != '0) begin
            #1;
            check("next_grant", 64'(req_ready), 64'(oh(next_grant(rest, g))));
        end
        req_valid = '0;
    endtask

    typedef struct {
        int               id;
        logic [W-1:0]     x, y, z;
        int               stall;
        logic [N_REQ-1:0] exp_rdy;
        logic [W-1:0]     exp_data;
        logic             exp_zero;
        int               exp_lat;
    } vec_t;

    initial begin
        vec_t tbl[6];
        logic [N_REQ-1:0] r_rdy, m;
        logic [W-1:0]     r_data;
        logic             r_zero;
        logic [ID_W-1:0]  r_id;
        int               r_lat;
        int               c, eg;
        int               gid[$];
        int               gcyc[$];
        logic             bad;

        tbl[0] = '{2, 24'h100000, 24'h000100, 24'h000001, 0, 4'b0100, 24'h4A5A5A, 1'b0, 12};
        tbl[1] = '{1, 24'h000000, 24'h000000, 24'h000000, 0, 4'b0010, 24'h000000, 1'b1, 0};
        tbl[2] = '{0, 24'hFFFFFF, 24'h000000, 24'h000000, 3, 4'b0001, 24'hA5A5A5, 1'b0, 12};
        tbl[3] = '{3, 24'h000000, 24'h000000, 24'h000001, 0, 4'b1000, 24'h5A5A5A, 1'b0, 12};
        tbl[4] = '{3, 24'h800000, 24'h800000, 24'h800000, 5, 4'b1000, 24'hDA5A5A, 1'b0, 12};
        tbl[5] = '{0, 24'h000000, 24'h000000, 24'h000000, 2, 4'b0001, 24'h000000, 1'b1, 0};

        // Reset values, with all requesters pushing during reset.
        rst = 1'b1; rsp_ready = 1'b1; req_valid = '1;
        for (int i = 0; i < N_REQ; i++) set_op(i, 24'h111111 * (i + 1), 24'h3, 24'h4);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_outputs", 64'({rsp_valid, busy, rsp_zero, rsp_id}), 64'(0));
        check("rst_eng", 64'({eng_x, eng_y}), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        rst = 1'b0; req_valid = '0; m_last = N_REQ - 1;
        @(posedge clk); #1;

        // Table-driven single requests.
        for (int v = 0; v < 6; v++) begin
            req_x = '0; req_y = '0; req_z = '0;
            set_op(tbl[v].id, tbl[v].x, tbl[v].y, tbl[v].z);
            m = oh(tbl[v].id);
            serve(m, tbl[v].stall, -1, r_rdy, r_data, r_zero, r_id, r_lat);
            m_last = tbl[v].id;
            check($sformatf("vec%0d_ready", v), 64'(r_rdy), 64'(tbl[v].exp_rdy));
            check($sformatf("vec%0d_data", v), 64'(r_data), 64'(tbl[v].exp_data));
            check($sformatf("vec%0d_zero", v), 64'(r_zero), 64'(tbl[v].exp_zero));
            check($sformatf("vec%0d_id", v), 64'(r_id), 64'(tbl[v].id));
            check($sformatf("vec%0d_lat", v), 64'(r_lat), 64'(tbl[v].exp_lat));
        end

        // Arbitration: all requesters held valid, responses drained at once.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, W'((i + 1) << 16), 24'h1, 24'h1);
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        c = 0;
        while (gid.size() < 5 && c < 200) begin
            if (req_ready != '0) begin
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gid.push_back(i);
                gcyc.push_back(c);
            end
            @(posedge clk); #2; c++;
        end
        req_valid = '0;
        check("arb_count", 64'(gid.size()), 64'(5));
        for (int j = 0; j < gid.size(); j++) begin
            eg = next_grant('1, m_last);
            check($sformatf("arb_id%0d", j), 64'(gid[j]), 64'(eg));
            m_last = eg;
            if (j > 0) check($sformatf("arb_gap%0d", j), 64'(gcyc[j] - gcyc[j-1]), 64'(LAT + 3));
        end
        c = 0;
        while (busy && c < 40) begin @(posedge clk); #1; c++; end
        check("arb_drain", 64'(busy), 64'(0));

        // Backpressure: 20-cycle stall with another requester waiting.
        set_op(0, 24'h0ABCDE, 24'h2, 24'h3);
        set_op(1, 24'h012345, 24'h0, 24'h7);
        eg = next_grant(4'b0011, m_last);
        serve(4'b0011, 20, -1, r_rdy, r_data, r_zero, r_id, r_lat);
        check("bp_ready", 64'(r_rdy), 64'(oh(eg)));
        check("bp_data", 64'(r_data), 64'(req_x[eg*W +: W] ^ 24'h5A5A5A));
        check("bp_lat", 64'(r_lat), 64'(LAT + 1));
        m_last = eg;

        // Withdrawn request: requester 3 raises and drops valid while busy.
        set_op(0, 24'h222222, 24'h1, 24'h0);
        serve(4'b0001, 0, 3, r_rdy, r_data, r_zero, r_id, r_lat);
        check("wd_id", 64'(r_id), 64'(0));
        m_last = 0;
        bad = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            if (req_ready != '0 || rsp_valid) bad = 1'b1;
        end
        check("wd_never_granted", 64'(bad), 64'(0));

        // Reset mid-RUN.
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 24'h123456, 24'h1, 24'h2);
        set_op(1, 24'h654321, 24'h1, 24'h2);
        req_valid = 4'b0001;
        #1;
        check("mr_accept", 64'(req_ready), 64'(4'b0001));
        @(posedge clk); #1;
        req_valid = '0;
        bad = 1'b0;
        for (int e = 1; e <= LAT - 5; e++) begin
            @(posedge clk); #1;
            if (rsp_valid) bad = 1'b1;
        end
        check("mr_no_rsp", 64'(bad), 64'(0));
        rst = 1'b1;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        check("mr_req_ready", 64'(req_ready), 64'(0));
        check("mr_ctrl", 64'({rsp_valid, busy, rsp_zero, rsp_id}), 64'(0));
        check("mr_eng", 64'({eng_x, eng_y}), 64'(0));
        check("mr_rsp_data", 64'(rsp_data), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0; m_last = N_REQ - 1;
        serve(4'b0011, 0, -1, r_rdy, r_data, r_zero, r_id, r_lat);
        check("mr_next_ready", 64'(r_rdy), 64'(4'b0001));
        check("mr_next_data", 64'(r_data), 64'(24'h123456 ^ 24'h5A5A5A));
        check("mr_next_lat", 64'(r_lat), 64'(12));
        m_last = 0;

        // Randomized traffic against the transaction-level model.
        for (int r = 0; r < 25; r++) begin
            logic [W-1:0] ex;
            logic         ez;
            m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 3) == 0) set_op(i, '0, '0, '0);
                else set_op(i, W'($urandom), W'($urandom), ($urandom_range(0, 1) == 0) ? '0 : W'($urandom));
            end
            eg = next_grant(m, m_last);
            ez = (req_x[eg*W +: W] == '0) && (req_y[eg*W +: W] == '0) && (req_z[eg*W +: W] == '0);
            ex = ez ? '0 : (req_x[eg*W +: W] ^ 24'h5A5A5A);
            serve(m, $urandom_range(0, 3), -1, r_rdy, r_data, r_zero, r_id, r_lat);
            check($sformatf("rnd%0d_ready", r), 64'(r_rdy), 64'(oh(eg)));
            check($sformatf("rnd%0d_data", r), 64'(r_data), 64'(ex));
            check($sformatf("rnd%0d_zero", r), 64'(r_zero), 64'(ez));
            check($sformatf("rnd%0d_id", r), 64'(r_id), 64'(eg));
            check($sformatf("rnd%0d_lat", r), 64'(r_lat), 64'(ez ? 0 : LAT + 1));
            m_last = eg;
        end

        check("operand_stability", 64'(stab_err), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
